// File: rtl/sram_uart_tx_interface_pkg.sv
// Shared state encodings and frame helpers for the SRAM-to-UART dump path.
// Frame bit index: 0 = start, 1..8 = data LSB first, 9 = stop.
package sram_uart_tx_interface_pkg;

   typedef enum logic [2:0] {
      S_TX_IDLE,
      S_TX_ADDR,
      S_TX_WAIT,
      S_TX_HI,
      S_TX_LO,
      S_TX_DONE
   } sram_tx_state_type;

   typedef enum logic [1:0] {
      S_TOP_IDLE,
      S_UART_RX,
      S_UART_TX
   } top_state_type;

   localparam logic [3:0] STOP_BIT_IDX = 4'd9;

   function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
      if (idx == 4'd0) return 1'b0;
      if (idx >= STOP_BIT_IDX) return 1'b1;
      return data[3'(idx - 4'd1)];
   endfunction

endpackage

// File: rtl/sram_uart_tx_interface_uart_tx_byte.sv
// 8N1 byte serialiser: load starts the start bit on the next cycle, each bit held CLKS_PER_BIT cycles.
// byte_done_o marks the last stop-bit cycle so a load in that cycle chains the next byte with no gap.
module uart_tx_byte
   import sram_uart_tx_interface_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
)(
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   input  logic              load_i,
   input  logic [7:0]        data_i,
   input  logic              clear_i,
   output logic              tx_o,
   output logic              byte_done_o,
   output logic [3:0]        bit_cnt_o,
   output logic [BAUD_W-1:0] baud_cnt_o
);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   logic              active_q;
   logic [7:0]        shift_q;
   logic [3:0]        bit_q;
   logic [BAUD_W-1:0] baud_q;
   logic              tx_q;
   logic              bit_end;

   assign bit_end     = active_q && (baud_q == BAUD_LAST);
   assign byte_done_o = bit_end && (bit_q == STOP_BIT_IDX);
   assign tx_o        = tx_q;
   assign bit_cnt_o   = bit_q;
   assign baud_cnt_o  = baud_q;

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         active_q <= 1'b0;
         shift_q  <= '0;
         bit_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
      end else if (clear_i) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
      end else if (load_i) begin
         active_q <= 1'b1;
         shift_q  <= data_i;
         bit_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b0;
      end else if (byte_done_o) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
      end else if (bit_end) begin
         bit_q    <= bit_q + 4'd1;
         baud_q   <= '0;
         tx_q     <= frame_bit(shift_q, bit_q + 4'd1);
      end else if (active_q) begin
         baud_q   <= baud_q + 1'b1;
      end
   end

endmodule

// File: rtl/sram_uart_tx_interface.sv
// Streams Word_count SRAM words from Base_address out of UART_TX_O, high byte first, back to back.
// The next word is prefetched during each high byte so SRAM latency never opens a gap on the line.
module sram_uart_tx_interface
   import sram_uart_tx_interface_pkg::*;
#(
   parameter int CLKS_PER_BIT      = 434,
   parameter int SRAM_READ_LATENCY = 2
)(
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        Start,
   input  logic        Abort,
   input  logic [17:0] Base_address,
   input  logic [17:0] Word_count,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic        SRAM_we_n,
   output logic        UART_TX_O,
   output logic        Busy,
   output logic        Done
);

   localparam int         BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [3:0] LAT    = 4'(SRAM_READ_LATENCY);

   sram_tx_state_type state_q;
   logic [17:0]       addr_q;
   logic [17:0]       remaining_q;
   logic [15:0]       word_buf_q;
   logic [15:0]       next_buf_q;
   logic [3:0]        lat_cnt_q;
   logic              start_load_q;
   logic [17:0]       sram_address_q;
   logic              busy_q;
   logic              done_q;

   logic              ser_load;
   logic [7:0]        ser_data;
   logic              ser_clear;
   logic              ser_done;
   logic [3:0]        ser_bit_cnt;
   logic [BAUD_W-1:0] ser_baud_cnt;
   logic              pf_issue;

   assign SRAM_address = sram_address_q;
   assign SRAM_we_n    = 1'b1;
   assign Busy         = busy_q;
   assign Done         = done_q;

   assign ser_clear = Abort && (state_q != S_TX_IDLE) && (state_q != S_TX_DONE);

   // Prefetch once per high byte, as its first data bit begins; 9 bit times remain to land it.
   assign pf_issue = (state_q == S_TX_HI) && (remaining_q > 18'd1) && (lat_cnt_q == 4'd0)
                     && (ser_bit_cnt == 4'd1) && (ser_baud_cnt == '0);

   always_comb begin
      ser_load = 1'b0;
      ser_data = word_buf_q[15:8];
      if (start_load_q) begin
         ser_load = 1'b1;
      end else if (ser_done && (state_q == S_TX_HI)) begin
         ser_load = 1'b1;
         ser_data = word_buf_q[7:0];
      end else if (ser_done && (state_q == S_TX_LO) && (remaining_q > 18'd1)) begin
         ser_load = 1'b1;
         ser_data = next_buf_q[15:8];
      end
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
      .CLOCK_50_I  (CLOCK_50_I),
      .resetn      (resetn),
      .load_i      (ser_load),
      .data_i      (ser_data),
      .clear_i     (ser_clear),
      .tx_o        (UART_TX_O),
      .byte_done_o (ser_done),
      .bit_cnt_o   (ser_bit_cnt),
      .baud_cnt_o  (ser_baud_cnt)
   );

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q        <= S_TX_IDLE;
         addr_q         <= '0;
         remaining_q    <= '0;
         word_buf_q     <= '0;
         next_buf_q     <= '0;
         lat_cnt_q      <= '0;
         start_load_q   <= 1'b0;
         sram_address_q <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         start_load_q <= 1'b0;
         case (state_q)
            S_TX_IDLE: begin
               if (Start && !Abort) begin
                  addr_q      <= Base_address;
                  remaining_q <= Word_count;
                  busy_q      <= 1'b1;
                  state_q     <= (Word_count == 18'd0) ? S_TX_DONE : S_TX_ADDR;
               end
            end
            S_TX_ADDR: begin
               sram_address_q <= addr_q;
               lat_cnt_q      <= '0;
               state_q        <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (lat_cnt_q == LAT) begin
                  word_buf_q   <= SRAM_read_data;
                  addr_q       <= addr_q + 18'd1;
                  lat_cnt_q    <= '0;
                  start_load_q <= 1'b1;
                  state_q      <= S_TX_HI;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 4'd1;
               end
            end
            S_TX_HI: begin
               if (pf_issue) begin
                  sram_address_q <= addr_q;
                  lat_cnt_q      <= 4'd1;
               end else if (lat_cnt_q == LAT + 4'd1) begin
                  next_buf_q <= SRAM_read_data;
                  addr_q     <= addr_q + 18'd1;
                  lat_cnt_q  <= '0;
               end else if (lat_cnt_q != 4'd0) begin
                  lat_cnt_q <= lat_cnt_q + 4'd1;
               end
               if (ser_done) state_q <= S_TX_LO;
            end
            S_TX_LO: begin
               if (ser_done) begin
                  remaining_q <= remaining_q - 18'd1;
                  lat_cnt_q   <= '0;
                  if (remaining_q == 18'd1) begin
                     state_q <= S_TX_DONE;
                  end else begin
                     word_buf_q <= next_buf_q;
                     state_q    <= S_TX_HI;
                  end
               end
            end
            S_TX_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_TX_IDLE;
            end
            default: state_q <= S_TX_IDLE;
         endcase
         if (ser_clear) state_q <= S_TX_DONE;
      end
   end

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed bench for sram_uart_tx_interface: SRAM model with 2-cycle read latency,
// UART receiver sampling mid-bit, and hand-derived timing/byte expectations.
module tb_sram_uart_tx_interface;

   localparam int CPB      = 32;
   localparam int BYTE_CYC = 10 * CPB;

   logic        clk    = 1'b0;
   logic        resetn = 1'b1;
   logic        start  = 1'b0;
   logic        abort  = 1'b0;
   logic [17:0] base   = '0;
   logic [17:0] count  = '0;
   logic [17:0] sram_addr;
   logic [15:0] rd_data;
   logic        we_n, tx, busy, done;

   always #10 clk = ~clk;

   sram_uart_tx_interface #(.CLKS_PER_BIT(CPB), .SRAM_READ_LATENCY(2)) dut (
      .CLOCK_50_I     (clk),
      .resetn         (resetn),
      .Start          (start),
      .Abort          (abort),
      .Base_address   (base),
      .Word_count     (count),
      .SRAM_address   (sram_addr),
      .SRAM_read_data (rd_data),
      .SRAM_we_n      (we_n),
      .UART_TX_O      (tx),
      .Busy           (busy),
      .Done           (done)
   );

   logic [15:0] mem [0:262143];
   logic [15:0] rd1, rd2;
   always @(posedge clk) begin
      rd1 <= mem[sram_addr];
      rd2 <= rd1;
   end
   assign rd_data = rd2;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Loopback receiver and bus monitors, all sampled on the falling edge.
   int          kill_req = 0, kill_ack = 0;
   int          cyc = 0, done_cnt = 0, frm_err = 0, rx_cnt = 0;
   logic        rx_on = 1'b0;
   logic [9:0]  rx_bits = '0;
   logic [17:0] last_addr = '0;
   logic [7:0]  rxq [$];
   int          startq [$];
   logic [17:0] addrq [$];

   initial forever begin
      @(negedge clk);
      cyc++;
      if (kill_req != kill_ack) begin
         kill_ack = kill_req;
         rxq.delete(); startq.delete(); addrq.delete();
         done_cnt = 0; frm_err = 0; rx_on = 1'b0;
         last_addr = sram_addr;
      end else begin
         if (done === 1'b1) done_cnt++;
         if (sram_addr !== last_addr) begin
            addrq.push_back(sram_addr);
            last_addr = sram_addr;
         end
         if (!rx_on) begin
            if (tx === 1'b0) begin
               rx_on = 1'b1; rx_cnt = 0;
               startq.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               rx_bits[4'(rx_cnt / CPB)] = tx;
               if (rx_cnt / CPB == 9) begin
                  rx_on = 1'b0;
                  if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) frm_err++;
                  rxq.push_back(rx_bits[8:1]);
               end
            end
         end
      end
   end

   task automatic flush();
      kill_req++;
      repeat (2) @(negedge clk);
   endtask

   task automatic go(input logic [17:0] b, input logic [17:0] c);
      base = b; count = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_starts(input string t, input int k, input int budget);
      int n = 0;
      while (startq.size() < k && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({t, " start seen"}, 32'(startq.size() >= k), 32'd1);
   endtask

   task automatic check_words(input string t, input logic [17:0] b, input int nw);
      logic [17:0] a;
      logic [15:0] w;
      chk({t, " nbytes"}, rxq.size(), 2 * nw);
      chk({t, " framing"}, frm_err, 0);
      for (int i = 0; i < nw; i++) begin
         a = b + 18'(i);
         w = mem[a];
         if (2 * i + 1 < rxq.size()) begin
            chk($sformatf("%s hi%0d", t, i), 32'(rxq[2*i]),   32'(w[15:8]));
            chk($sformatf("%s lo%0d", t, i), 32'(rxq[2*i+1]), 32'(w[7:0]));
         end
      end
      for (int i = 1; i < startq.size(); i++)
         chk($sformatf("%s gap%0d", t, i), startq[i] - startq[i-1], BYTE_CYC);
   endtask

   int n;

   initial begin
      for (int i = 0; i < 262144; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
      mem[18'h00100] = 16'hA55A;
      #5 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst tx",   32'(tx),        32'd1);
      chk("rst busy", 32'(busy),      32'd0);
      chk("rst done", 32'(done),      32'd0);
      chk("rst addr", 32'(sram_addr), 32'd0);
      chk("rst we_n", 32'(we_n),      32'd1);
      resetn = 1'b1;
      @(negedge clk);
      flush();

      // 1: single word 0xA55A -> bytes A5 then 5A
      go(18'h00100, 18'd1);
      chk("t1 busy", 32'(busy), 32'd1);
      wait_done(25 * CPB, n);
      chk("t1 done", 32'(done), 32'd1);
      chk("t1 latency", n + 1, 20 * CPB + 7);
      @(negedge clk);
      chk("t1 done pulse", 32'(done), 32'd0);
      chk("t1 busy end",   32'(busy), 32'd0);
      chk("t1 nbytes", rxq.size(), 2);
      if (rxq.size() == 2) begin
         chk("t1 byte0", 32'(rxq[0]), 32'h A5);
         chk("t1 byte1", 32'(rxq[1]), 32'h 5A);
      end
      check_words("t1", 18'h00100, 1);
      chk("t1 naddr", addrq.size(), 1);
      if (addrq.size() == 1) chk("t1 addr", 32'(addrq[0]), 32'h100);

      // 2: address wrap across 0x3FFFF
      flush();
      go(18'h3FFFE, 18'd4);
      wait_done(90 * CPB, n);
      chk("t2 done", 32'(done), 32'd1);
      @(negedge clk);
      check_words("t2", 18'h3FFFE, 4);
      chk("t2 naddr", addrq.size(), 4);
      if (addrq.size() == 4) begin
         chk("t2 addr0", 32'(addrq[0]), 32'h3FFFE);
         chk("t2 addr1", 32'(addrq[1]), 32'h3FFFF);
         chk("t2 addr2", 32'(addrq[2]), 32'h00000);
         chk("t2 addr3", 32'(addrq[3]), 32'h00001);
      end
      chk("t2 done count", done_cnt, 1);

      // 3: zero-length transfer, then Start together with Abort
      flush();
      go(18'h00777, 18'd0);
      chk("t3 busy c1", 32'(busy), 32'd1);
      chk("t3 done c1", 32'(done), 32'd0);
      @(negedge clk);
      chk("t3 done c2", 32'(done), 32'd1);
      chk("t3 busy c2", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t3 done c3", 32'(done), 32'd0);
      repeat (3 * CPB) @(negedge clk);
      chk("t3 no bytes", startq.size(), 0);
      chk("t3 no addr",  addrq.size(), 0);
      chk("t3 tx idle",  32'(tx), 32'd1);
      flush();
      abort = 1'b1;
      go(18'h00123, 18'd1);
      abort = 1'b0;
      chk("t3b busy", 32'(busy), 32'd0);
      repeat (4 * CPB) @(negedge clk);
      chk("t3b done count", done_cnt, 0);
      chk("t3b no bytes", startq.size(), 0);
      chk("t3b no addr", addrq.size(), 0);

      // 4: Abort partway into the second byte, then a clean restart
      flush();
      go(18'h00200, 18'd10);
      wait_starts("t4", 2, 30 * CPB);
      repeat (100) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4 tx after abort", 32'(tx), 32'd1);
      @(negedge clk);
      chk("t4 done", 32'(done), 32'd1);
      chk("t4 busy", 32'(busy), 32'd0);
      repeat (2 * BYTE_CYC) @(negedge clk);
      chk("t4 done count", done_cnt, 1);
      chk("t4 tx idle", 32'(tx), 32'd1);
      chk("t4 byte0", 32'(rxq.size() > 0 ? rxq[0] : 8'h00), 32'(mem[18'h00200][15:8]));
      flush();
      go(18'h00300, 18'd2);
      wait_done(50 * CPB, n);
      chk("t4r done", 32'(done), 32'd1);
      @(negedge clk);
      check_words("t4r", 18'h00300, 2);

      // 5: Start pulses while Busy are ignored
      flush();
      go(18'h00400, 18'd3);
      repeat (50) @(negedge clk);
      go(18'h00010, 18'd1);
      repeat (BYTE_CYC) @(negedge clk);
      go(18'h00020, 18'd5);
      wait_done(70 * CPB, n);
      chk("t5 done", 32'(done), 32'd1);
      repeat (3 * CPB) @(negedge clk);
      chk("t5 done count", done_cnt, 1);
      chk("t5 busy", 32'(busy), 32'd0);
      check_words("t5", 18'h00400, 3);
      chk("t5 naddr", addrq.size(), 3);
      if (addrq.size() == 3) chk("t5 addr2", 32'(addrq[2]), 32'h402);

      // 6: reset in the middle of a start bit
      flush();
      go(18'h00500, 18'd2);
      wait_starts("t6", 1, 20 * CPB);
      repeat (CPB / 2) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("t6 tx", 32'(tx), 32'd1);
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 addr", 32'(sram_addr), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      flush();
      go(18'h00600, 18'd2);
      wait_done(50 * CPB, n);
      chk("t6r done", 32'(done), 32'd1);
      @(negedge clk);
      check_words("t6r", 18'h00600, 2);
      chk("t6r done count", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
